// File: rtl/lsu_pkg.sv
// Shared encodings, request payload and lane-extension helper for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  typedef struct packed {
    logic            write;
    logic [1:0]      size;
    logic            sgn;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Widen a byte or half lane to a full word, replicating the lane's top bit when signed.
  function automatic logic [XLEN-1:0] lane_ext(input logic [15:0] lane, input logic is_half,
                                               input logic sgn);
    logic top;
    top = is_half ? lane[15] : lane[7];
    if (is_half) return {{16{sgn & top}}, lane};
    return {{24{sgn & top}}, lane[7:0]};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends load lanes, merges store lanes into a fetched word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            sgn,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_c,
  output logic [XLEN-1:0] merge_c
);

  logic [4:0]      bsh;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;

  always_comb begin
    bsh     = (size == SZ_HALF) ? {off[1], 4'b0000} : {off, 3'b000};
    shifted = rdata >> bsh;
    mask    = '0;
    load_c  = rdata;
    merge_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_c = lane_ext(shifted[15:0], 1'b0, sgn);
        mask   = 32'h0000_00ff << bsh;
      end
      SZ_HALF: begin
        load_c = lane_ext(shifted[15:0], 1'b1, sgn);
        mask   = 32'h0000_ffff << bsh;
      end
      default: ;
    endcase
    if (size == SZ_BYTE || size == SZ_HALF)
      merge_c = (rdata & ~mask) | ((wdata << bsh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Word-port load/store initiator with read-modify-write for sub-word stores.
// Optional access counters enabled by defining LSU_ACCESS_COUNT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
`ifdef LSU_ACCESS_COUNT_EN
  ,
  output logic [XLEN-1:0] load_count,
  output logic [XLEN-1:0] store_count
`endif
);

  localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(MEM_WORDS) << 2;

  logic [1:0]      state, state_nxt;
  lsu_req_t        req_q;
  logic            accept;
  logic            err_in;
  logic [XLEN-1:0] load_c, merge_c;

  logic            req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [XLEN-1:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

  assign accept = req_valid && (state == ST_IDLE);

  // Misalignment, reserved size or beyond the backing store all fail without touching memory.
  always_comb begin
    err_in = ({1'b0, req_addr} >= ADDR_LIMIT);
    case (req_size)
      SZ_HALF: err_in = err_in | req_addr[0];
      SZ_WORD: err_in = err_in | (|req_addr[1:0]);
      SZ_RSVD: err_in = 1'b1;
      default: ;
    endcase
  end

  lsu_align u_align (
    .size    (req_q.size),
    .off     (req_q.off),
    .sgn     (req_q.sgn),
    .rdata   (mem_rdata),
    .wdata   (req_q.wdata),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  always_comb begin
    state_nxt    = state;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (err_in) begin
            state_nxt  = ST_RESP;
            resp_err_d = 1'b1;
          end else begin
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wdata_d = req_wdata;
            state_nxt   = (req_write && req_size == SZ_WORD) ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        if (req_q.write) begin
          state_nxt   = ST_WR;
          mem_wdata_d = merge_c;
        end else begin
          state_nxt    = ST_RESP;
          resp_rdata_d = load_c;
        end
      end
      ST_WR:   state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
    req_ready_d  = (state_nxt == ST_IDLE);
    resp_valid_d = (state_nxt == ST_RESP);
    mem_read_d   = (state_nxt == ST_RD);
    mem_write_d  = (state_nxt == ST_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      if (accept)
        req_q <= '{write: req_write, size: req_size, sgn: req_signed,
                   off: req_addr[1:0], wdata: req_wdata};
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

`ifdef LSU_ACCESS_COUNT_EN
  logic err_q;

  // Completed accesses are tallied as the unit leaves RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (accept) err_q <= err_in;
      if (state == ST_RESP && !err_q) begin
        if (req_q.write) store_count <= store_count + 32'd1;
        else             load_count  <= load_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit paired with a negedge-commit word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_ACCESS_COUNT_EN
  logic [31:0] load_count, store_count;
`endif

  load_store_unit #(.MEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_ACCESS_COUNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  assign mem_rdata = mem[mem_addr[12:2]];
  always @(negedge clk) if (mem_write) mem[mem_addr[12:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ld_exp = 0;
  int st_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are matched in order against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
        chk({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
        chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        chk({e.tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      end
    end
    if (!rst && (mem_read || mem_write)) begin
      acc_cnt++;
      chk("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
    end
  end

  task automatic issue(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    e.rdata = er; e.err = ee; e.acc = cyc; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    if (!ee) begin
      if (wr) st_exp++;
      else    ld_exp++;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_before;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    issue("sw10", 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    issue("lw10", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    issue("sw20", 1, SZ_WORD, 0, 32'h20, 32'h11223344, 32'h0, 0, 2);
    issue("sb21", 1, SZ_BYTE, 0, 32'h21, 32'hFFFFFFAA, 32'h0, 0, 3);
    issue("lb21", 0, SZ_BYTE, 1, 32'h21, 32'h0, 32'hFFFFFFAA, 0, 2);
    issue("lbu21", 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'h000000AA, 0, 2);
    issue("sh32", 1, SZ_HALF, 0, 32'h32, 32'h12348001, 32'h0, 0, 3);
    issue("lh32", 0, SZ_HALF, 1, 32'h32, 32'h0, 32'hFFFF8001, 0, 2);
    issue("lhu32", 0, SZ_HALF, 0, 32'h32, 32'h0, 32'h00008001, 0, 2);
    issue("sb23", 1, SZ_BYTE, 0, 32'h23, 32'h0000007F, 32'h0, 0, 3);
    issue("lb23", 0, SZ_BYTE, 1, 32'h23, 32'h0, 32'h0000007F, 0, 2);
    issue("lhu20", 0, SZ_HALF, 0, 32'h20, 32'h0, 32'h0000AA44, 0, 2);
    drain();
    chk("mem_10", mem[4], 32'hDEADBEEF);
    chk("mem_20", mem[8], 32'h7F22AA44);
    chk("mem_30", mem[12], 32'h80010000);

    acc_before = acc_cnt;
    issue("err_lw13", 0, SZ_WORD, 0, 32'h13, 32'h0, 32'h0, 1, 1);
    issue("err_lh31", 0, SZ_HALF, 1, 32'h31, 32'h0, 32'h0, 1, 1);
    issue("err_rsvd", 1, SZ_RSVD, 0, 32'h20, 32'h55555555, 32'h0, 1, 1);
    issue("err_sw2000", 1, SZ_WORD, 0, 32'h2000, 32'h12345678, 32'h0, 1, 1);
    drain();
    chk("err_no_mem_access", 32'(acc_cnt - acc_before), 32'd0);
    chk("err_mem_00", mem[0], 32'h0);
    chk("err_mem_20", mem[8], 32'h7F22AA44);

`ifdef LSU_ACCESS_COUNT_EN
    repeat (2) @(negedge clk);
    chk("load_count", load_count, 32'(ld_exp));
    chk("store_count", store_count, 32'(st_exp));
`endif

    // Abort a word store while it is in its write cycle.
    mem[16] = 32'hCAFE0000;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_wr_high", 32'(mem_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_low", 32'(mem_write), 32'd0);
    @(negedge clk);
    #1;
    chk("abort_mem_40", mem[16], 32'hCAFE0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
`ifdef LSU_ACCESS_COUNT_EN
    chk("rst_load_count", load_count, 32'd0);
`endif

    issue("lw40", 0, SZ_WORD, 0, 32'h40, 32'h0, 32'hCAFE0000, 0, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
